// File: rtl/comb_differencer.sv
`default_nettype none
// ============================================================================
//  Module      : comb_differencer
//  Description : Streaming comb stage y[n] = x[n] - x[n-M] with a runtime M,
//                valid/ready on both sides. Define COMB_SAT_EN for a
//                saturating difference and the sat_flag output.
//  Revision    : 1.0 - initial release
// ============================================================================
module comb_differencer #(
    parameter int W     = 32,
    parameter int MAX_M = 8,
    parameter int MW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clear,
    input  logic [MW-1:0] m_sel,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
`ifdef COMB_SAT_EN
    output logic          sat_flag,
`endif
    output logic          primed
);

    localparam int PW = (MAX_M > 1) ? $clog2(MAX_M) : 1;

    logic [W-1:0]  r_buf [MAX_M];
    logic [PW-1:0] r_wp;
    logic [MW-1:0] r_fill;
    logic [MW-1:0] r_m_lat;
    logic          r_out_valid;
    logic [W-1:0]  r_out_data;

    logic [MW-1:0] w_m_req;
    logic [PW-1:0] w_wp_last;
    logic          w_primed;
    logic          w_accept;
    logic          w_drain;
    logic [W-1:0]  w_old;
    logic [W-1:0]  w_diff;

    always_comb begin
        w_m_req = m_sel;
        if (m_sel == '0) begin
            w_m_req = MW'(1);
        end else if (m_sel > MW'(MAX_M)) begin
            w_m_req = MW'(MAX_M);
        end
    end

    assign w_wp_last = PW'(r_m_lat - MW'(1));
    assign w_primed  = (r_fill == r_m_lat);
    assign in_ready  = en & ~reset & ~clear & (~r_out_valid | out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_drain   = r_out_valid & out_ready & en;

    // Until M samples exist the missing history reads as zero, so stale
    // buffer contents never reach the output.
    assign w_old = w_primed ? r_buf[r_wp] : '0;

`ifdef COMB_SAT_EN
    logic [W:0] w_wide;
    logic       w_ovf;

    assign w_wide = {in_data[W-1], in_data} - {w_old[W-1], w_old};
    assign w_ovf  = w_wide[W] ^ w_wide[W-1];

    always_comb begin
        w_diff = w_wide[W-1:0];
        if (w_ovf) begin
            w_diff = w_wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    logic r_sat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat <= 1'b0;
        end else if (en && !clear && w_accept) begin
            r_sat <= w_ovf;
        end
    end

    assign sat_flag = r_sat;
`else
    assign w_diff = in_data - w_old;
`endif

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wp] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_wp        <= '0;
            r_fill      <= '0;
            r_m_lat     <= w_m_req;
        end else if (en) begin
            if (clear) begin
                r_out_valid <= 1'b0;
                r_wp        <= '0;
                r_fill      <= '0;
                r_m_lat     <= w_m_req;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_diff;
                r_wp        <= (r_wp == w_wp_last) ? '0 : r_wp + PW'(1);
                r_fill      <= w_primed ? r_fill : r_fill + MW'(1);
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign primed    = w_primed;

endmodule
`default_nettype wire

// File: tb/tb_comb_differencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comb_differencer
//  Description : Self-checking bench for comb_differencer (W=32, MAX_M=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comb_differencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  m_sel = 4'd1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        primed;
`ifdef COMB_SAT_EN
    logic        sat_flag;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] hist[$];
    int          m_model = 1;
    logic [31:0] last_out = '0;

    comb_differencer #(.W(32), .MAX_M(8), .MW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clear     (clear),
        .m_sel     (m_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef COMB_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .primed    (primed)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int map_m(input int s);
        if (s == 0) return 1;
        if (s > 8) return 8;
        return s;
    endfunction

    // y = x - x[n-M]; absent history counts as zero.
    task automatic model_push(input logic [31:0] x, output logic [31:0] y, output logic sat);
        logic [31:0] old;
        longint      d;
        old = (hist.size() >= m_model) ? hist[hist.size() - m_model] : 32'd0;
        hist.push_back(x);
        if (hist.size() > 8) void'(hist.pop_front());
        sat = 1'b0;
`ifdef COMB_SAT_EN
        d = longint'($signed(x)) - longint'($signed(old));
        if (d > 64'sd2147483647) begin
            d = 64'sd2147483647;  sat = 1'b1;
        end else if (d < -64'sd2147483648) begin
            d = -64'sd2147483648; sat = 1'b1;
        end
        y = d[31:0];
`else
        d = 0;
        y = x - old;
`endif
    endtask

    task automatic do_reset(input logic [3:0] s);
        @(negedge clk);
        reset = 1'b1; m_sel = s; in_valid = 1'b1; en = 1'b1;
        #1 check("in_ready_in_reset", in_ready, 0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        hist.delete(); m_model = map_m(s);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_primed", primed, 0);
        last_out = '0;
    endtask

    task automatic do_clear(input logic [3:0] s);
        clear = 1'b1; m_sel = s; in_valid = 1'b1; en = 1'b1; out_ready = 1'b0;
        #1 check("in_ready_in_clear", in_ready, 0);
        @(posedge clk); @(negedge clk);
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        hist.delete(); m_model = map_m(s);
        check("clr_out_valid", out_valid, 0);
        check("clr_out_data_kept", out_data, last_out);
        check("clr_primed", primed, 0);
    endtask

    task automatic send(input logic [31:0] x);
        logic [31:0] e;
        logic        es;
        in_valid = 1'b1; in_data = x; out_ready = 1'b1; en = 1'b1;
        #1 check("in_ready", in_ready, 1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        model_push(x, e, es);
        last_out = e;
        check("out_valid", out_valid, 1);
        check("out_data", out_data, e);
        check("primed", primed, (hist.size() >= m_model) ? 1 : 0);
`ifdef COMB_SAT_EN
        check("sat_flag", sat_flag, es);
`endif
    endtask

    task automatic drain_idle();
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("drained", out_valid, 0);
    endtask

    initial begin
        @(negedge clk);

        do_reset(4'd1);
        send(32'd5); send(32'd7); send(32'd4);
        check("m1_last", out_data, 32'hFFFF_FFFD);
        drain_idle();

        do_reset(4'd3);
        for (int i = 1; i <= 6; i++) send(32'(i));
        drain_idle();

        do_reset(4'd1);
        send(32'h7FFF_FFFF); send(32'h8000_0000);
        drain_idle();

        // Backpressure, enable stall, and an m_sel change that must be ignored
        do_reset(4'd2);
        for (int i = 0; i < 3; i++) send($urandom);
        in_valid = 1'b1; in_data = $urandom; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", in_ready, 0);
            @(posedge clk); @(negedge clk);
            check("bp_valid_held", out_valid, 1);
            check("bp_data_held", out_data, last_out);
        end
        send(in_data);
        in_valid = 1'b1; in_data = $urandom; out_ready = 1'b1; en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 check("en_in_ready", in_ready, 0);
            @(posedge clk); @(negedge clk);
            check("en_valid_held", out_valid, 1);
            check("en_data_held", out_data, last_out);
        end
        send(in_data);
        m_sel = 4'd4;
        send($urandom);
        do_clear(4'd4);
        for (int i = 0; i < 10; i++) send($urandom);
        drain_idle();

        do_reset(4'd0);
        for (int i = 0; i < 6; i++) send($urandom);
        do_reset(4'd15);
        for (int i = 0; i < 12; i++) send($urandom);
        do_clear(4'd5);
        for (int i = 0; i < 12; i++) send($urandom_range(0, 1000));

        for (int m = 1; m <= 8; m++) begin
            do_reset(4'(m));
            for (int i = 0; i < m + 4; i++) begin
                if ($urandom_range(0, 3) == 0) drain_idle();
                send($urandom);
            end
        end
        drain_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
